// File: rtl/decode_stage_p.sv
// decode_stage_p
//   Decode stage of the 32-bit pipelined core. Holds the 16-entry register
//   file, reads both source operands (with PC+8 aliasing and an optional
//   same-cycle writeback bypass), sign-extends the immediate, and registers
//   the decoded fields into the ID/EX pipeline register. Detects load-use
//   hazards against the instruction currently in EX and inserts one bubble.
//
//   Handshake: in_valid qualifies pc_in/instr_in/mem_read_d. While stall_f is
//   high, fetch must present the same instruction again next cycle; the
//   instruction is consumed on a rising edge where stall_f is low.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   in_valid, pc_in, instr_in  instruction in decode (RA1=[25:22],
//                              WA3=[21:18], RA2=[17:14])
//   mem_read_d                 decode instruction is a load
//   stall_in                   downstream stall, hold ID/EX
//   flush                      taken branch, kill ID/EX
//   reg_write_w, wa3_w,
//   result_w                   writeback port into the register file
//   rd1_e, rd2_e, imm_e, pc8_e,
//   ra1_e, ra2_e, wa3_e,
//   mem_read_e, valid_e        ID/EX pipeline register outputs
//   stall_f                    combinational hold request to fetch/decode
module decode_stage_p #(
    parameter int XLEN   = 32,
    parameter int IMM_W  = 24,
    parameter int PC_REG = 15,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    input  logic            mem_read_d,
    input  logic            stall_in,
    input  logic            flush,
    input  logic            reg_write_w,
    input  logic [3:0]      wa3_w,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_e,
    output logic [XLEN-1:0] pc8_e,
    output logic [3:0]      ra1_e,
    output logic [3:0]      ra2_e,
    output logic [3:0]      wa3_e,
    output logic            mem_read_e,
    output logic            valid_e,
    output logic            stall_f
);

    localparam logic [3:0] PC_IDX = 4'(PC_REG);
    localparam int         EXT_W  = XLEN - IMM_W;

    logic [XLEN-1:0] rf [16];

    logic [3:0]      ra1;
    logic [3:0]      ra2;
    logic [3:0]      wa3;
    logic [XLEN-1:0] pc8;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            hazard;

    assign ra1 = instr_in[25:22];
    assign wa3 = instr_in[21:18];
    assign ra2 = instr_in[17:14];
    assign pc8 = pc_in + XLEN'(8);

    generate
        if (EXT_W > 0) begin : g_sext
            assign imm = {{EXT_W{instr_in[IMM_W-1]}}, instr_in[IMM_W-1:0]};
        end else begin : g_noext
            assign imm = instr_in[IMM_W-1:0];
        end
    endgenerate

    // PC alias beats the bypass; a write to PC_REG can never match here
    // because the bypass path is only reached for ra != PC_REG.
    always_comb begin
        rd1 = rf[ra1];
        if (ra1 == PC_IDX) begin
            rd1 = pc8;
        end else if ((BYPASS != 0) && reg_write_w && (wa3_w == ra1)) begin
            rd1 = result_w;
        end
        rd2 = rf[ra2];
        if (ra2 == PC_IDX) begin
            rd2 = pc8;
        end else if ((BYPASS != 0) && reg_write_w && (wa3_w == ra2)) begin
            rd2 = result_w;
        end
    end

    // Load in EX whose destination is a source of the decode instruction.
    // Both sources count as used regardless of the opcode.
    assign hazard = in_valid & valid_e & mem_read_e & (wa3_e != PC_IDX) &
                    (((ra1 == wa3_e) & (ra1 != PC_IDX)) |
                     ((ra2 == wa3_e) & (ra2 != PC_IDX)));

    // Reset gating keeps fetch released while reset is held.
    assign stall_f = ~reset & (stall_in | (hazard & ~flush));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                rf[i] <= '0;
            end
        end else if (reg_write_w && (wa3_w != PC_IDX)) begin
            rf[wa3_w] <= result_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_e      <= '0;
            pc8_e      <= '0;
            ra1_e      <= '0;
            ra2_e      <= '0;
            wa3_e      <= '0;
            mem_read_e <= 1'b0;
            valid_e    <= 1'b0;
        end else if (flush || (!stall_in && hazard)) begin
            // Flush and hazard bubble both clear the whole register.
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_e      <= '0;
            pc8_e      <= '0;
            ra1_e      <= '0;
            ra2_e      <= '0;
            wa3_e      <= '0;
            mem_read_e <= 1'b0;
            valid_e    <= 1'b0;
        end else if (!stall_in) begin
            rd1_e      <= rd1;
            rd2_e      <= rd2;
            imm_e      <= imm;
            pc8_e      <= pc8;
            ra1_e      <= ra1;
            ra2_e      <= ra2;
            wa3_e      <= wa3;
            mem_read_e <= mem_read_d & in_valid;
            valid_e    <= in_valid;
        end
    end

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc8;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa3;
        logic        mr;
        logic        valid;
    } exp_t;

    localparam int K_LOAD = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, mem_read_d, stall_in, flush, reg_write_w;
    logic [31:0] pc_in, instr_in, result_w;
    logic [3:0]  wa3_w;

    logic [31:0] rd1_e, rd2_e, imm_e, pc8_e;
    logic [3:0]  ra1_e, ra2_e, wa3_e;
    logic        mem_read_e, valid_e, stall_f;

    logic [31:0] nb_rd1_e, nb_rd2_e, nb_imm_e, nb_pc8_e;
    logic [3:0]  nb_ra1_e, nb_ra2_e, nb_wa3_e;
    logic        nb_mem_read_e, nb_valid_e, nb_stall_f;

    decode_stage_p #(.XLEN(32), .IMM_W(24), .PC_REG(15), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in),
        .instr_in(instr_in), .mem_read_d(mem_read_d), .stall_in(stall_in),
        .flush(flush), .reg_write_w(reg_write_w), .wa3_w(wa3_w),
        .result_w(result_w), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .pc8_e(pc8_e), .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e),
        .mem_read_e(mem_read_e), .valid_e(valid_e), .stall_f(stall_f)
    );

    decode_stage_p #(.XLEN(32), .IMM_W(24), .PC_REG(15), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in),
        .instr_in(instr_in), .mem_read_d(mem_read_d), .stall_in(stall_in),
        .flush(flush), .reg_write_w(reg_write_w), .wa3_w(wa3_w),
        .result_w(result_w), .rd1_e(nb_rd1_e), .rd2_e(nb_rd2_e), .imm_e(nb_imm_e),
        .pc8_e(nb_pc8_e), .ra1_e(nb_ra1_e), .ra2_e(nb_ra2_e), .wa3_e(nb_wa3_e),
        .mem_read_e(nb_mem_read_e), .valid_e(nb_valid_e), .stall_f(nb_stall_f)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t last_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] ra1, input logic [3:0] wa3,
                                       input logic [3:0] ra2);
        return {6'b0, ra1, wa3, ra2, 14'h0123};
    endfunction

    // ---------------- driver ----------------
    // Drives one decode cycle, checks stall_f, queues the ID/EX contents
    // expected after the following rising edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic mr, input logic st, input logic fl,
                       input logic rw, input logic [3:0] wa, input logic [31:0] res,
                       input int kind, input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                       input logic e_sf);
        exp_t e;
        @(negedge clk);
        in_valid = v; pc_in = pc; instr_in = ins; mem_read_d = mr;
        stall_in = st; flush = fl; reg_write_w = rw; wa3_w = wa; result_w = res;
        #1;
        chk("stall_f", {31'b0, stall_f}, {31'b0, e_sf});
        e = '0;
        if (kind == K_LOAD) begin
            e.rd1   = e_rd1;
            e.rd2   = e_rd2;
            e.imm   = {{8{ins[23]}}, ins[23:0]};
            e.pc8   = pc + 32'd8;
            e.ra1   = ins[25:22];
            e.wa3   = ins[21:18];
            e.ra2   = ins[17:14];
            e.mr    = mr & v;
            e.valid = v;
        end else if (kind == K_HOLD) begin
            e = last_exp;
        end
        last_exp = e;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.rd1 = rd1_e; a.rd2 = rd2_e; a.imm = imm_e; a.pc8 = pc8_e;
                a.ra1 = ra1_e; a.ra2 = ra2_e; a.wa3 = wa3_e;
                a.mr = mem_read_e; a.valid = valid_e;
                checks++;
                // Data fields of a dead ID/EX entry are don't-care.
                if (e.valid ? (a !== e) : ({a.mr, a.valid} !== {e.mr, e.valid})) begin
                    failures++;
                    $display("FAIL idex @%0t: got %h expected %h", $time, a, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        in_valid = 0; pc_in = 0; instr_in = 0; mem_read_d = 0;
        stall_in = 0; flush = 0; reg_write_w = 0; wa3_w = 0; result_w = 0;
        last_exp = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_valid_e", {31'b0, valid_e}, 32'd0);
        chk("reset_rd1_e", rd1_e, 32'd0);
        chk("reset_pc8_e", pc8_e, 32'd0);

        // Bypass: write R5 and read it in the same cycle.
        cyc(1, 32'h200, mk(5, 1, 0), 0, 0, 0, 1, 4'd5, 32'hDEADBEEF, K_LOAD, 32'hDEADBEEF, 32'h0, 0);
        #1 chk("nobypass_rd1_e", nb_rd1_e, 32'h0);
        // PC register read, with a discarded write to R15.
        cyc(1, 32'h100, mk(5, 1, 15), 0, 0, 0, 1, 4'd15, 32'h55, K_LOAD, 32'hDEADBEEF, 32'h108, 0);
        cyc(1, 32'h100, mk(15, 1, 15), 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h108, 32'h108, 0);
        // Immediates at the sign boundary.
        cyc(1, 32'h104, 32'h00800001, 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h0, 0);
        cyc(1, 32'h300, 32'h007FFFFF, 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h308, 0);
        // Load-use: one bubble, writeback of the load during the bubble.
        cyc(1, 32'h400, mk(0, 4, 0), 1, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h0, 0);
        cyc(1, 32'h404, mk(4, 6, 0), 0, 0, 0, 1, 4'd4, 32'h1234, K_BUB, 32'h0, 32'h0, 1);
        cyc(1, 32'h404, mk(4, 6, 0), 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h1234, 32'h0, 0);
        // Load to PC_REG never stalls.
        cyc(1, 32'h500, mk(0, 15, 0), 1, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h0, 0);
        cyc(1, 32'h504, mk(15, 2, 0), 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h50C, 32'h0, 0);
        // Flush together with a hazard.
        cyc(1, 32'h600, mk(0, 4, 0), 1, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h0, 0);
        cyc(1, 32'h604, mk(4, 6, 0), 0, 0, 1, 0, 4'd0, 32'h0, K_BUB, 32'h0, 32'h0, 0);
        cyc(1, 32'h700, mk(4, 1, 5), 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h1234, 32'hDEADBEEF, 0);
        // Downstream stall for three cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h900 + 32'(i), mk(3, 3, 3), 1, 1, 0, 0, 4'd0, 32'h0, K_HOLD, 32'h0, 32'h0, 1);
        end
        // Stall overlapping a hazard: hold, then bubble, then issue.
        cyc(1, 32'h800, mk(0, 9, 0), 1, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h0, 0);
        cyc(1, 32'h804, mk(0, 6, 9), 0, 1, 0, 0, 4'd0, 32'h0, K_HOLD, 32'h0, 32'h0, 1);
        cyc(1, 32'h804, mk(0, 6, 9), 0, 0, 0, 1, 4'd9, 32'h99, K_BUB, 32'h0, 32'h0, 1);
        cyc(1, 32'h804, mk(0, 6, 9), 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h99, 0);
        // in_valid=0 is a bubble; following instruction sees no hazard.
        cyc(0, 32'h808, mk(0, 3, 0), 1, 0, 0, 1, 4'd3, 32'h33, K_LOAD, 32'h0, 32'h0, 0);
        cyc(1, 32'h80C, mk(3, 1, 0), 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h33, 32'h0, 0);

        // Asynchronous reset in the middle of a cycle.
        #3;
        stall_in = 1'b1;
        reset    = 1'b1;
        #1;
        chk("midreset_valid_e", {31'b0, valid_e}, 32'd0);
        chk("midreset_rd1_e", rd1_e, 32'd0);
        chk("midreset_imm_e", imm_e, 32'd0);
        chk("midreset_pc8_e", pc8_e, 32'd0);
        chk("midreset_idx", {20'b0, ra1_e, ra2_e, wa3_e}, 32'd0);
        chk("midreset_stall_f", {31'b0, stall_f}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        stall_in = 1'b0;
        last_exp = '0;
        // Registers were cleared.
        cyc(1, 32'hA00, mk(3, 0, 5), 0, 0, 0, 0, 4'd0, 32'h0, K_LOAD, 32'h0, 32'h0, 0);

        @(negedge clk);
        in_valid = 0; reg_write_w = 0; mem_read_d = 0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
